// File: rtl/booth_ctrl.sv
// booth_ctrl: radix-2 Booth signed multiplier sequencer driving an external (2N+1)-bit shift register
//   clk, rst (async, active-high)       clock and reset
//   start, mcand, mplier                request and signed operands, sampled in IDLE
//   busy, done, product                 handshake and signed product (sr_q[2N:1])
//   sr_load, sr_shren, sr_din, sr_data  shift-register controls
//   sr_q                                shift-register contents
module booth_ctrl #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic           sr_load,
  output logic           sr_shren,
  output logic           sr_din,
  output logic [2*N:0]   sr_data,
  input  logic [2*N:0]   sr_q
);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, EVAL = 3'd2, SHIFT = 3'd3, DONE = 3'd4;
  logic [2:0]    r_state;
  logic [N-1:0]  r_m;
  logic [N-1:0]  r_q;
  logic          r_a_ext;
  logic [CW-1:0] r_cnt;
  logic [N:0]    w_a;
  logic [N:0]    w_m;
  logic [N:0]    w_sum;
  logic          w_op;
  // r_a_ext extends A to N+1 bits so the accumulator never overflows
  assign w_a      = {r_a_ext, sr_q[2*N:N+1]};
  assign w_m      = {r_m[N-1], r_m};
  assign w_sum    = sr_q[1] ? w_a - w_m : w_a + w_m;
  assign w_op     = (r_state == EVAL) && (sr_q[1] ^ sr_q[0]);
  assign busy     = r_state != IDLE;
  assign done     = r_state == DONE;
  assign product  = sr_q[2*N:1];
  assign sr_load  = (r_state == LOAD) || w_op;
  assign sr_shren = r_state == SHIFT;
  assign sr_din   = sr_shren & r_a_ext;
  assign sr_data  = (r_state == LOAD) ? {{N{1'b0}}, r_q, 1'b0} :
                    w_op              ? {w_sum[N-1:0], sr_q[N:0]} : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_m     <= '0;
      r_q     <= '0;
      r_a_ext <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_m     <= mcand;
          r_q     <= mplier;
          r_a_ext <= 1'b0;
          r_cnt   <= '0;
          r_state <= LOAD;
        end
        LOAD: r_state <= EVAL;
        EVAL: begin
          if (w_op) r_a_ext <= w_sum[N];
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_cnt   <= r_cnt + 1'b1;
          r_state <= (r_cnt == CW'(N - 1)) ? DONE : EVAL;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: directed and random checks of booth_ctrl against a cycle-level behavioural model
module tb_booth_ctrl;
  localparam int N = 8;
  localparam int LAT = 2 * N + 1;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [7:0]   mcand = '0;
  logic [7:0]   mplier = '0;
  logic         busy, done, sr_load, sr_shren, sr_din;
  logic [15:0]  product;
  logic [16:0]  sr_data;
  logic [16:0]  sr;
  int           vec = 0;
  int           bad = 0;
  int           cyc = 0;
  int           age;
  logic [15:0]  m_exp, m_last;

  always #5 clk = ~clk;

  booth_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product),
    .sr_load(sr_load), .sr_shren(sr_shren), .sr_din(sr_din), .sr_data(sr_data),
    .sr_q(sr)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else if (sr_shren) sr <= {sr_din, sr[16:1]};
    else if (sr_load) sr <= sr_data;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ref_mul(input logic signed [7:0] a, input logic signed [7:0] b);
    int p;
    p = int'(a) * int'(b);
    return p[15:0];
  endfunction

  // age = cycles since the accepting edge, -1 when idle
  always @(posedge clk or posedge rst)
    if (rst) begin
      age <= -1; m_exp <= '0; m_last <= '0;
    end else if (age < 0) begin
      if (start) begin
        age <= 0; m_exp <= ref_mul(mcand, mplier);
      end
    end else if (age == LAT) begin
      age <= -1; m_last <= m_exp;
    end else age <= age + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input bit pulse);
    int n, bc, extra;
    @(posedge clk); #2;
    start = 1'b1; mcand = a; mplier = b;
    @(posedge clk); #2;
    start = 1'b0;
    n = 0; bc = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
      if (done) break;
      if (pulse) start = n[0];
    end
    start = 1'b0;
    chk("latency", n, 18);
    chk("busy_len", bc, 18);
    chk("product_lit", product, exp);
    if (pulse) begin
      extra = 0;
      repeat (20) begin
        @(negedge clk);
        if (done) extra++;
      end
      chk("extra_done", extra, 0);
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          chk("busy", busy, age >= 0);
          chk("done", done, age == LAT);
          chk("excl", sr_load & sr_shren, 0);
          if (age == LAT) chk("product", product, m_exp);
          else if (age <= 0) chk("hold", product, m_last);
        end
      end
      begin
        int n, dc[$];
        logic [7:0] a, b;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_load", sr_load, 0);
        chk("rst_shren", sr_shren, 0);
        chk("rst_din", sr_din, 0);
        chk("rst_data", sr_data, 0);
        chk("rst_product", product, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        run_op(8'd3, 8'd5, 16'h000F, 0);
        run_op(8'hF9, 8'd6, 16'hFFD6, 0);
        run_op(8'd6, 8'hF9, 16'hFFD6, 0);
        run_op(8'h80, 8'h80, 16'h4000, 0);
        run_op(8'h80, 8'h7F, 16'hC080, 0);
        run_op(8'h7F, 8'h7F, 16'h3F01, 0);
        run_op(8'h00, 8'hFF, 16'h0000, 0);
        run_op(8'd2, 8'd3, 16'h0006, 1);
        @(posedge clk); #2;
        start = 1'b1; mcand = 8'd100; mplier = 8'hCE;
        @(posedge clk); #2;
        start = 1'b0;
        n = 0;
        while (age != 8 && n < 30) begin
          @(negedge clk);
          n++;
        end
        chk("reach_iter3", age, 8);
        #1 rst = 1'b1;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_load", sr_load | sr_shren | sr_din, 0);
        chk("mid_data", sr_data, 0);
        chk("mid_product", product, 0);
        repeat (2) begin
          @(negedge clk);
          chk("mid_done", done, 0);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        run_op(8'd3, 8'd5, 16'h000F, 0);
        @(posedge clk); #2;
        start = 1'b1; mcand = 8'd5; mplier = 8'hFD;
        n = 0;
        while (dc.size() < 3 && n < 100) begin
          @(negedge clk);
          n++;
          if (done) begin
            dc.push_back(cyc);
            chk("b2b_product", product, 16'hFFF1);
          end
        end
        start = 1'b0;
        chk("b2b_count", dc.size(), 3);
        if (dc.size() == 3) begin
          chk("b2b_gap1", dc[1] - dc[0], 19);
          chk("b2b_gap2", dc[2] - dc[1], 19);
        end
        repeat (1000) begin
          a = 8'($urandom_range(0, 255));
          b = 8'($urandom_range(0, 255));
          run_op(a, b, ref_mul(a, b), 0);
        end
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
      end
    join_any
  end
endmodule
